fpalu_arb: RTL and testbench

Two-port round-robin scheduler that shares one FPALU instance between two requesters. It accepts operand/opcode requests over valid/ready handshakes and issues at most one operation per cycle to the FPALU in the unified format: sign, 6-bit exponent, 22-bit left-aligned denormal mantissa. It tracks every in-flight operation through the FPALU's fixed latency and returns each result on a shared response bus tagged with requester ID and request tag. It sits between the instruction-issue logic and the FPALU datapath.

---
 rtl/fpalu_arb_if.sv | 90 +++++++++
 rtl/fpalu_arb.sv | 221 ++++++++++++++++++++++
 tb/tb_fpalu_arb.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpalu_arb_if.sv
// -----------------------------------------------------------------------------
// fpalu_arb_if
// Bundle of every non-clock signal around the FPALU round-robin scheduler.
//   sched_en          : global grant enable
//   req0_* / req1_*   : requester ports (vld/rdy handshake, opcode, operands A/B
//                       in unified format sign/6-bit exp/22-bit mantissa, tag)
//   alu_a_* / alu_b_* : registered operands driven to the FPALU
//   alu_add_muln      : registered opcode driven to the FPALU (1 = add)
//   alu_y_*           : FPALU result
//   rsp_*             : tagged response bus (single-cycle rsp_vld, no backpressure)
//   busy              : an op is in flight or a response is being presented
// Modport slave is the scheduler's view, master is the environment's view.
// -----------------------------------------------------------------------------
interface fpalu_arb_if #(
    parameter int TAG_W = 4
);
    logic             sched_en;

    logic             req0_vld;
    logic             req0_rdy;
    logic             req0_add_muln;
    logic             req0_a_sgn;
    logic [5:0]       req0_a_exp;
    logic [21:0]      req0_a_man_dn;
    logic             req0_b_sgn;
    logic [5:0]       req0_b_exp;
    logic [21:0]      req0_b_man_dn;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_vld;
    logic             req1_rdy;
    logic             req1_add_muln;
    logic             req1_a_sgn;
    logic [5:0]       req1_a_exp;
    logic [21:0]      req1_a_man_dn;
    logic             req1_b_sgn;
    logic [5:0]       req1_b_exp;
    logic [21:0]      req1_b_man_dn;
    logic [TAG_W-1:0] req1_tag;

    logic             alu_a_sgn;
    logic [5:0]       alu_a_exp;
    logic [21:0]      alu_a_man_dn;
    logic             alu_b_sgn;
    logic [5:0]       alu_b_exp;
    logic [21:0]      alu_b_man_dn;
    logic             alu_add_muln;

    logic             alu_y_sgn;
    logic [5:0]       alu_y_exp;
    logic [21:0]      alu_y_man_dn;

    logic             rsp_vld;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_y_sgn;
    logic [5:0]       rsp_y_exp;
    logic [21:0]      rsp_y_man_dn;
    logic             busy;

    modport slave (
        input  sched_en,
        input  req0_vld, req0_add_muln, req0_a_sgn, req0_a_exp, req0_a_man_dn,
               req0_b_sgn, req0_b_exp, req0_b_man_dn, req0_tag,
        output req0_rdy,
        input  req1_vld, req1_add_muln, req1_a_sgn, req1_a_exp, req1_a_man_dn,
               req1_b_sgn, req1_b_exp, req1_b_man_dn, req1_tag,
        output req1_rdy,
        output alu_a_sgn, alu_a_exp, alu_a_man_dn,
               alu_b_sgn, alu_b_exp, alu_b_man_dn, alu_add_muln,
        input  alu_y_sgn, alu_y_exp, alu_y_man_dn,
        output rsp_vld, rsp_id, rsp_tag, rsp_y_sgn, rsp_y_exp, rsp_y_man_dn,
        output busy
    );

    modport master (
        output sched_en,
        output req0_vld, req0_add_muln, req0_a_sgn, req0_a_exp, req0_a_man_dn,
               req0_b_sgn, req0_b_exp, req0_b_man_dn, req0_tag,
        input  req0_rdy,
        output req1_vld, req1_add_muln, req1_a_sgn, req1_a_exp, req1_a_man_dn,
               req1_b_sgn, req1_b_exp, req1_b_man_dn, req1_tag,
        input  req1_rdy,
        input  alu_a_sgn, alu_a_exp, alu_a_man_dn,
               alu_b_sgn, alu_b_exp, alu_b_man_dn, alu_add_muln,
        output alu_y_sgn, alu_y_exp, alu_y_man_dn,
        input  rsp_vld, rsp_id, rsp_tag, rsp_y_sgn, rsp_y_exp, rsp_y_man_dn,
        input  busy
    );
endinterface

// File: rtl/fpalu_arb.sv
// -----------------------------------------------------------------------------
// fpalu_arb
// Two-port round-robin scheduler sharing one fixed-latency FPALU.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fpalu_arb_if.slave (requests, FPALU operands/result, responses)
// Parameters:
//   LAT   : FPALU latency in edges from operands driven to result valid (1..8)
//   TAG_W : request tag width
// At most one request is accepted per cycle. The accepted operands are held in
// the alu_* registers until the next acceptance; a LAT+1 deep {vld,id,tag} pipe
// follows each op so that its result is captured into the response registers
// one edge after the FPALU delivers it.
// -----------------------------------------------------------------------------
module fpalu_arb #(
    parameter int LAT   = 1,
    parameter int TAG_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    fpalu_arb_if.slave bus
);

    // grant / acceptance
    logic             gnt0_s;
    logic             gnt1_s;
    logic             accept_s;
    logic             acc_id_s;
    logic             prio_r;

    // operand set of the granted requester
    logic             sel_add_muln_s;
    logic             sel_a_sgn_s;
    logic [5:0]       sel_a_exp_s;
    logic [21:0]      sel_a_man_s;
    logic             sel_b_sgn_s;
    logic [5:0]       sel_b_exp_s;
    logic [21:0]      sel_b_man_s;
    logic [TAG_W-1:0] sel_tag_s;

    // FPALU operand registers
    logic             alu_add_muln_r;
    logic             alu_a_sgn_r;
    logic [5:0]       alu_a_exp_r;
    logic [21:0]      alu_a_man_r;
    logic             alu_b_sgn_r;
    logic [5:0]       alu_b_exp_r;
    logic [21:0]      alu_b_man_r;

    // in-flight tracking pipe, stage 0 is loaded at the acceptance edge
    logic [LAT:0]     pipe_vld_r;
    logic [LAT:0]     pipe_id_r;
    logic [TAG_W-1:0] pipe_tag_r [0:LAT];

    // response registers
    logic             rsp_vld_r;
    logic             rsp_id_r;
    logic [TAG_W-1:0] rsp_tag_r;
    logic             rsp_y_sgn_r;
    logic [5:0]       rsp_y_exp_r;
    logic [21:0]      rsp_y_man_r;
    logic             busy_r;

    // Round-robin grant: prio wins a tie, a lone requester always wins
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (bus.sched_en) begin
            if (bus.req0_vld && bus.req1_vld) begin
                if (prio_r) begin
                    gnt1_s = 1'b1;
                end else begin
                    gnt0_s = 1'b1;
                end
            end else if (bus.req0_vld) begin
                gnt0_s = 1'b1;
            end else if (bus.req1_vld) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign accept_s     = gnt0_s | gnt1_s;
    assign acc_id_s     = gnt1_s;
    assign bus.req0_rdy = gnt0_s;
    assign bus.req1_rdy = gnt1_s;

    // Operand mux driven by the winning requester id
    always_comb begin
        sel_add_muln_s = bus.req0_add_muln;
        sel_a_sgn_s    = bus.req0_a_sgn;
        sel_a_exp_s    = bus.req0_a_exp;
        sel_a_man_s    = bus.req0_a_man_dn;
        sel_b_sgn_s    = bus.req0_b_sgn;
        sel_b_exp_s    = bus.req0_b_exp;
        sel_b_man_s    = bus.req0_b_man_dn;
        sel_tag_s      = bus.req0_tag;
        if (acc_id_s) begin
            sel_add_muln_s = bus.req1_add_muln;
            sel_a_sgn_s    = bus.req1_a_sgn;
            sel_a_exp_s    = bus.req1_a_exp;
            sel_a_man_s    = bus.req1_a_man_dn;
            sel_b_sgn_s    = bus.req1_b_sgn;
            sel_b_exp_s    = bus.req1_b_exp;
            sel_b_man_s    = bus.req1_b_man_dn;
            sel_tag_s      = bus.req1_tag;
        end else begin
            sel_add_muln_s = bus.req0_add_muln;
            sel_a_sgn_s    = bus.req0_a_sgn;
            sel_a_exp_s    = bus.req0_a_exp;
            sel_a_man_s    = bus.req0_a_man_dn;
            sel_b_sgn_s    = bus.req0_b_sgn;
            sel_b_exp_s    = bus.req0_b_exp;
            sel_b_man_s    = bus.req0_b_man_dn;
            sel_tag_s      = bus.req0_tag;
        end
    end

    // Priority pointer and FPALU operand registers; both update only on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r         <= 1'b0;
            alu_add_muln_r <= 1'b0;
            alu_a_sgn_r    <= 1'b0;
            alu_a_exp_r    <= 6'd0;
            alu_a_man_r    <= 22'd0;
            alu_b_sgn_r    <= 1'b0;
            alu_b_exp_r    <= 6'd0;
            alu_b_man_r    <= 22'd0;
        end else if (accept_s) begin
            prio_r         <= ~acc_id_s;
            alu_add_muln_r <= sel_add_muln_s;
            alu_a_sgn_r    <= sel_a_sgn_s;
            alu_a_exp_r    <= sel_a_exp_s;
            alu_a_man_r    <= sel_a_man_s;
            alu_b_sgn_r    <= sel_b_sgn_s;
            alu_b_exp_r    <= sel_b_exp_s;
            alu_b_man_r    <= sel_b_man_s;
        end else begin
            prio_r         <= prio_r;
            alu_add_muln_r <= alu_add_muln_r;
            alu_a_sgn_r    <= alu_a_sgn_r;
            alu_a_exp_r    <= alu_a_exp_r;
            alu_a_man_r    <= alu_a_man_r;
            alu_b_sgn_r    <= alu_b_sgn_r;
            alu_b_exp_r    <= alu_b_exp_r;
            alu_b_man_r    <= alu_b_man_r;
        end
    end

    // Tracking pipe: free-running shift, never stalls; id/tag only matter when vld
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_r <= '0;
            pipe_id_r  <= '0;
            for (int i = 0; i <= LAT; i++) begin
                pipe_tag_r[i] <= '0;
            end
        end else begin
            pipe_vld_r    <= {pipe_vld_r[LAT-1:0], accept_s};
            pipe_id_r     <= {pipe_id_r[LAT-1:0], acc_id_s};
            pipe_tag_r[0] <= sel_tag_s;
            for (int i = 1; i <= LAT; i++) begin
                pipe_tag_r[i] <= pipe_tag_r[i-1];
            end
        end
    end

    // Response capture when the op at the pipe tail has its FPALU result ready.
    // busy_r is the registered form of (any pipe vld | rsp_vld) for the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_r   <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_tag_r   <= '0;
            rsp_y_sgn_r <= 1'b0;
            rsp_y_exp_r <= 6'd0;
            rsp_y_man_r <= 22'd0;
            busy_r      <= 1'b0;
        end else begin
            rsp_vld_r <= pipe_vld_r[LAT];
            busy_r    <= accept_s | (|pipe_vld_r);
            if (pipe_vld_r[LAT]) begin
                rsp_id_r    <= pipe_id_r[LAT];
                rsp_tag_r   <= pipe_tag_r[LAT];
                rsp_y_sgn_r <= bus.alu_y_sgn;
                rsp_y_exp_r <= bus.alu_y_exp;
                rsp_y_man_r <= bus.alu_y_man_dn;
            end else begin
                rsp_id_r    <= rsp_id_r;
                rsp_tag_r   <= rsp_tag_r;
                rsp_y_sgn_r <= rsp_y_sgn_r;
                rsp_y_exp_r <= rsp_y_exp_r;
                rsp_y_man_r <= rsp_y_man_r;
            end
        end
    end

    assign bus.alu_add_muln = alu_add_muln_r;
    assign bus.alu_a_sgn    = alu_a_sgn_r;
    assign bus.alu_a_exp    = alu_a_exp_r;
    assign bus.alu_a_man_dn = alu_a_man_r;
    assign bus.alu_b_sgn    = alu_b_sgn_r;
    assign bus.alu_b_exp    = alu_b_exp_r;
    assign bus.alu_b_man_dn = alu_b_man_r;

    assign bus.rsp_vld      = rsp_vld_r;
    assign bus.rsp_id       = rsp_id_r;
    assign bus.rsp_tag      = rsp_tag_r;
    assign bus.rsp_y_sgn    = rsp_y_sgn_r;
    assign bus.rsp_y_exp    = rsp_y_exp_r;
    assign bus.rsp_y_man_dn = rsp_y_man_r;
    assign bus.busy         = busy_r;

endmodule

// File: tb/tb_fpalu_arb.sv
// -----------------------------------------------------------------------------
// tb_fpalu_arb
// Directed bench for fpalu_arb. dut1 is built with LAT=1, dut4 with LAT=4; each
// is paired with a small behavioural FPALU of matching latency. Inputs change
// 1 time unit after the rising edge, outputs are checked on the falling edge.
// Loop index c below counts cycles; an acceptance at the end of cycle c gives
// a response visible in cycle c+LAT+2.
// -----------------------------------------------------------------------------
module tb_fpalu_arb;
    localparam int TAG_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fpalu_arb_if #(.TAG_W(TAG_W)) bus1 ();
    fpalu_arb_if #(.TAG_W(TAG_W)) bus4 ();

    fpalu_arb #(.LAT(1), .TAG_W(TAG_W)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    fpalu_arb #(.LAT(4), .TAG_W(TAG_W)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    // Operand A of requester p carrying tag t: {sgn, exp, man}
    function automatic logic [28:0] op_a(input logic p, input logic [3:0] t);
        return {t[1], 1'b0, p, t, 22'h15A5A0 | {18'd0, t}};
    endfunction

    function automatic logic [28:0] op_b(input logic p, input logic [3:0] t);
        return {p, 6'd5, 22'h3C0000 >> t};
    endfunction

    // Stand-in FPALU arithmetic; any fixed function of the operands will do
    function automatic logic [28:0] fpalu_fn(input logic [28:0] a, input logic [28:0] b,
                                             input logic add);
        logic [21:0] bm;
        logic [5:0]  ex;
        bm = b[21:0];
        ex = a[27:22] + b[27:22] + {5'd0, add};
        return {a[28] ^ b[28] ^ add, ex, a[21:0] ^ {bm[20:0], bm[21]}};
    endfunction

    // Requester p always uses add for port 0 and multiply for port 1
    function automatic logic [28:0] exp_y(input logic p, input logic [3:0] t);
        return fpalu_fn(op_a(p, t), op_b(p, t), ~p);
    endfunction

    logic [28:0] fp1_y;
    logic [28:0] fp4_q [0:3];

    always @(posedge clk) begin
        fp1_y <= fpalu_fn({bus1.alu_a_sgn, bus1.alu_a_exp, bus1.alu_a_man_dn},
                          {bus1.alu_b_sgn, bus1.alu_b_exp, bus1.alu_b_man_dn},
                          bus1.alu_add_muln);
    end

    always @(posedge clk) begin
        fp4_q[0] <= fpalu_fn({bus4.alu_a_sgn, bus4.alu_a_exp, bus4.alu_a_man_dn},
                             {bus4.alu_b_sgn, bus4.alu_b_exp, bus4.alu_b_man_dn},
                             bus4.alu_add_muln);
        for (int i = 1; i < 4; i++) fp4_q[i] <= fp4_q[i-1];
    end

    assign bus1.alu_y_sgn    = fp1_y[28];
    assign bus1.alu_y_exp    = fp1_y[27:22];
    assign bus1.alu_y_man_dn = fp1_y[21:0];
    assign bus4.alu_y_sgn    = fp4_q[3][28];
    assign bus4.alu_y_exp    = fp4_q[3][27:22];
    assign bus4.alu_y_man_dn = fp4_q[3][21:0];

    task automatic set_req1(input logic p, input logic vld, input logic [3:0] t);
        logic [28:0] a;
        logic [28:0] b;
        a = op_a(p, t);
        b = op_b(p, t);
        if (p == 1'b0) begin
            bus1.req0_vld = vld; bus1.req0_tag = t; bus1.req0_add_muln = 1'b1;
            {bus1.req0_a_sgn, bus1.req0_a_exp, bus1.req0_a_man_dn} = a;
            {bus1.req0_b_sgn, bus1.req0_b_exp, bus1.req0_b_man_dn} = b;
        end else begin
            bus1.req1_vld = vld; bus1.req1_tag = t; bus1.req1_add_muln = 1'b0;
            {bus1.req1_a_sgn, bus1.req1_a_exp, bus1.req1_a_man_dn} = a;
            {bus1.req1_b_sgn, bus1.req1_b_exp, bus1.req1_b_man_dn} = b;
        end
    endtask

    task automatic set_req4(input logic vld, input logic [3:0] t);
        bus4.req0_vld = vld; bus4.req0_tag = t; bus4.req0_add_muln = 1'b1;
        {bus4.req0_a_sgn, bus4.req0_a_exp, bus4.req0_a_man_dn} = op_a(1'b0, t);
        {bus4.req0_b_sgn, bus4.req0_b_exp, bus4.req0_b_man_dn} = op_b(1'b0, t);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus1.sched_en = 1'b1;
        bus4.sched_en = 1'b1;
        set_req1(1'b0, 1'b0, 4'd0);
        set_req1(1'b1, 1'b0, 4'd0);
        set_req4(1'b0, 4'd0);
        bus4.req1_vld = 1'b0; bus4.req1_tag = 4'd0; bus4.req1_add_muln = 1'b0;
        {bus4.req1_a_sgn, bus4.req1_a_exp, bus4.req1_a_man_dn} = 29'd0;
        {bus4.req1_b_sgn, bus4.req1_b_exp, bus4.req1_b_man_dn} = 29'd0;
        @(negedge clk);
        checks++;
        if ({bus1.req0_rdy, bus1.req1_rdy} !== 2'b00) begin
            errors++; $display("FAIL reset_rdy_idle got %b exp 00", {bus1.req0_rdy, bus1.req1_rdy});
        end
        checks++;
        if ({bus1.alu_a_sgn, bus1.alu_a_exp, bus1.alu_a_man_dn, bus1.alu_b_sgn, bus1.alu_b_exp,
             bus1.alu_b_man_dn, bus1.alu_add_muln} !== 59'd0) begin
            errors++; $display("FAIL reset_alu got %h exp 0", {bus1.alu_a_exp, bus1.alu_a_man_dn});
        end
        checks++;
        if ({bus1.rsp_vld, bus1.rsp_id, bus1.rsp_tag, bus1.rsp_y_sgn, bus1.rsp_y_exp,
             bus1.rsp_y_man_dn, bus1.busy} !== 36'd0) begin
            errors++; $display("FAIL reset_rsp got %h exp 0", {bus1.rsp_vld, bus1.rsp_tag, bus1.busy});
        end
        checks++;
        if ({bus4.rsp_vld, bus4.busy} !== 2'b00) begin
            errors++; $display("FAIL reset_lat4 got %b exp 00", {bus4.rsp_vld, bus4.busy});
        end
        // rdy stays combinational in reset; prio resets to requester 0
        set_req1(1'b0, 1'b1, 4'd0);
        set_req1(1'b1, 1'b1, 4'd0);
        #1;
        checks++;
        if ({bus1.req0_rdy, bus1.req1_rdy} !== 2'b10) begin
            errors++; $display("FAIL reset_rdy_both got %b exp 10", {bus1.req0_rdy, bus1.req1_rdy});
        end
        set_req1(1'b0, 1'b0, 4'd0);
        set_req1(1'b1, 1'b0, 4'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic exp_busy;
        set_req1(1'b0, 1'b1, 4'h3);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if ({bus1.req0_rdy, bus1.req1_rdy} !== 2'b10) begin
                    errors++; $display("FAIL single_rdy got %b exp 10", {bus1.req0_rdy, bus1.req1_rdy});
                end
            end
            if (c == 1) begin
                checks++;
                if ({bus1.alu_add_muln, bus1.alu_a_exp, bus1.alu_b_exp} !== {1'b1, 6'd3, 6'd5}) begin
                    errors++; $display("FAIL single_alu got %h exp %h",
                        {bus1.alu_add_muln, bus1.alu_a_exp, bus1.alu_b_exp}, {1'b1, 6'd3, 6'd5});
                end
            end
            if (c == 3) begin
                checks++;
                if ({bus1.rsp_vld, bus1.rsp_id, bus1.rsp_tag, bus1.rsp_y_sgn, bus1.rsp_y_exp,
                     bus1.rsp_y_man_dn} !== {1'b1, 1'b0, 4'h3, 1'b0, 6'd9, 22'h1AA5A3}) begin
                    errors++; $display("FAIL single_rsp got %h exp %h",
                        {bus1.rsp_vld, bus1.rsp_id, bus1.rsp_tag, bus1.rsp_y_sgn, bus1.rsp_y_exp,
                         bus1.rsp_y_man_dn}, {1'b1, 1'b0, 4'h3, 1'b0, 6'd9, 22'h1AA5A3});
                end
            end else begin
                checks++;
                if (bus1.rsp_vld !== 1'b0) begin
                    errors++; $display("FAIL single_rsp_idle c=%0d got %b exp 0", c, bus1.rsp_vld);
                end
            end
            exp_busy = (c >= 1 && c <= 3);
            checks++;
            if (bus1.busy !== exp_busy) begin
                errors++; $display("FAIL single_busy c=%0d got %b exp %b", c, bus1.busy, exp_busy);
            end
            @(posedge clk); #1;
            if (c == 0) set_req1(1'b0, 1'b0, 4'h3);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  t0;
        logic [3:0]  t1;
        logic        e;
        logic [3:0]  et;
        logic [34:0] exp_rsp;
        logic [1:0]  exp_rdy;
        t0 = 4'd0;
        t1 = 4'd0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            set_req1(1'b0, c < 6, t0);
            set_req1(1'b1, c < 6, t1);
            @(negedge clk);
            if (c < 6) begin
                exp_rdy = (c % 2 == 0) ? 2'b10 : 2'b01;
                checks++;
                if ({bus1.req0_rdy, bus1.req1_rdy} !== exp_rdy) begin
                    errors++; $display("FAIL b2b_rdy c=%0d got %b exp %b", c,
                        {bus1.req0_rdy, bus1.req1_rdy}, exp_rdy);
                end
            end
            if (c >= 3 && c < 9) begin
                e  = 1'((c - 3) % 2);
                et = 4'((c - 3) / 2);
                exp_rsp = {1'b1, e, et, exp_y(e, et)};
                checks++;
                if ({bus1.rsp_vld, bus1.rsp_id, bus1.rsp_tag, bus1.rsp_y_sgn, bus1.rsp_y_exp,
                     bus1.rsp_y_man_dn} !== exp_rsp) begin
                    errors++; $display("FAIL b2b_rsp c=%0d got %h exp %h", c,
                        {bus1.rsp_vld, bus1.rsp_id, bus1.rsp_tag, bus1.rsp_y_sgn, bus1.rsp_y_exp,
                         bus1.rsp_y_man_dn}, exp_rsp);
                end
            end else begin
                checks++;
                if (bus1.rsp_vld !== 1'b0) begin
                    errors++; $display("FAIL b2b_rsp_idle c=%0d got %b exp 0", c, bus1.rsp_vld);
                end
            end
            @(posedge clk); #1;
            if (c < 6) begin
                if (c % 2 == 0) t0 = t0 + 4'd1;
                else            t1 = t1 + 4'd1;
            end
        end
    endtask

    task automatic test_single_port_then_both();
        logic [4:0]  gnt1;
        logic [19:0] rsp_tags;
        logic [3:0]  t0;
        logic [3:0]  t1;
        logic [1:0]  exp_rdy;
        logic [5:0]  exp_rsp;
        gnt1     = 5'b10111;                               // grant owner per cycle, bit c
        rsp_tags = {4'd3, 4'd0, 4'd2, 4'd1, 4'd0};          // tag of response c-3, lsb first
        t0 = 4'd0;
        t1 = 4'd0;
        for (int c = 0; c < 8; c++) begin
            set_req1(1'b0, c == 3 || c == 4, t0);
            set_req1(1'b1, c < 5, t1);
            @(negedge clk);
            if (c < 5) begin
                exp_rdy = gnt1[c] ? 2'b01 : 2'b10;
                checks++;
                if ({bus1.req0_rdy, bus1.req1_rdy} !== exp_rdy) begin
                    errors++; $display("FAIL rr_rdy c=%0d got %b exp %b", c,
                        {bus1.req0_rdy, bus1.req1_rdy}, exp_rdy);
                end
            end
            if (c >= 3) begin
                exp_rsp = {1'b1, gnt1[c-3], rsp_tags[(c-3)*4 +: 4]};
                checks++;
                if ({bus1.rsp_vld, bus1.rsp_id, bus1.rsp_tag} !== exp_rsp) begin
                    errors++; $display("FAIL rr_rsp c=%0d got %h exp %h", c,
                        {bus1.rsp_vld, bus1.rsp_id, bus1.rsp_tag}, exp_rsp);
                end
            end
            @(posedge clk); #1;
            if (c < 5) begin
                if (gnt1[c]) t1 = t1 + 4'd1;
                else         t0 = t0 + 4'd1;
            end
        end
    endtask

    task automatic test_sched_en();
        logic [3:0] t0;
        logic [3:0] t1;
        logic [1:0] exp_rdy;
        logic       exp_busy;
        logic       exp_vld;
        t0 = 4'd0;
        t1 = 4'd0;
        for (int c = 0; c < 12; c++) begin
            bus1.sched_en = (c < 2 || c >= 8);
            set_req1(1'b0, c < 9, t0);
            set_req1(1'b1, c < 9, t1);
            @(negedge clk);
            if (c <= 8) begin
                case (c)
                    0:       exp_rdy = 2'b10;
                    1:       exp_rdy = 2'b01;
                    8:       exp_rdy = 2'b10;
                    default: exp_rdy = 2'b00;
                endcase
                checks++;
                if ({bus1.req0_rdy, bus1.req1_rdy} !== exp_rdy) begin
                    errors++; $display("FAIL sched_rdy c=%0d got %b exp %b", c,
                        {bus1.req0_rdy, bus1.req1_rdy}, exp_rdy);
                end
            end
            if (c >= 1 && c <= 7) begin
                exp_busy = (c <= 4);
                exp_vld  = (c == 3 || c == 4);
                checks++;
                if ({bus1.busy, bus1.rsp_vld} !== {exp_busy, exp_vld}) begin
                    errors++; $display("FAIL sched_busy_vld c=%0d got %b exp %b", c,
                        {bus1.busy, bus1.rsp_vld}, {exp_busy, exp_vld});
                end
            end
            if (c == 3 || c == 4 || c == 11) begin
                checks++;
                if ({bus1.rsp_id, bus1.rsp_tag} !== {c == 4, (c == 11) ? 4'd1 : 4'd0}) begin
                    errors++; $display("FAIL sched_rsp c=%0d got %h exp %h", c,
                        {bus1.rsp_id, bus1.rsp_tag}, {c == 4, (c == 11) ? 4'd1 : 4'd0});
                end
            end
            @(posedge clk); #1;
            if (c == 0 || c == 8) t0 = t0 + 4'd1;
            if (c == 1)           t1 = t1 + 4'd1;
        end
    endtask

    task automatic test_reset_mid_op();
        // last acceptance was requester 0, so requester 1 wins the first tie
        set_req1(1'b0, 1'b1, 4'h5);
        set_req1(1'b1, 1'b1, 4'h6);
        @(negedge clk);
        checks++;
        if ({bus1.req0_rdy, bus1.req1_rdy} !== 2'b01) begin
            errors++; $display("FAIL rst_mid_rdy0 got %b exp 01", {bus1.req0_rdy, bus1.req1_rdy});
        end
        @(posedge clk); #1;
        set_req1(1'b1, 1'b0, 4'h6);
        @(negedge clk);
        checks++;
        if ({bus1.req0_rdy, bus1.req1_rdy} !== 2'b10) begin
            errors++; $display("FAIL rst_mid_rdy1 got %b exp 10", {bus1.req0_rdy, bus1.req1_rdy});
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        set_req1(1'b0, 1'b0, 4'h5);
        @(negedge clk);
        checks++;
        if ({bus1.rsp_vld, bus1.rsp_id, bus1.rsp_tag, bus1.rsp_y_sgn, bus1.rsp_y_exp,
             bus1.rsp_y_man_dn, bus1.busy, bus1.alu_a_exp, bus1.alu_add_muln} !== 43'd0) begin
            errors++; $display("FAIL rst_mid_outputs got %h exp 0",
                {bus1.rsp_vld, bus1.rsp_tag, bus1.rsp_y_man_dn, bus1.busy, bus1.alu_a_exp});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({bus1.rsp_vld, bus1.busy} !== 2'b00) begin
                errors++; $display("FAIL rst_mid_quiet c=%0d got %b exp 00", c, {bus1.rsp_vld, bus1.busy});
            end
            @(posedge clk); #1;
        end
        set_req1(1'b0, 1'b1, 4'h7);
        set_req1(1'b1, 1'b1, 4'h8);
        @(negedge clk);
        checks++;
        if ({bus1.req0_rdy, bus1.req1_rdy} !== 2'b10) begin
            errors++; $display("FAIL rst_mid_first_gnt got %b exp 10", {bus1.req0_rdy, bus1.req1_rdy});
        end
        @(posedge clk); #1;
        set_req1(1'b0, 1'b0, 4'h7);
        set_req1(1'b1, 1'b0, 4'h8);
    endtask

    task automatic test_lat4();
        logic [3:0]  et;
        logic [34:0] exp_rsp;
        logic        exp_busy;
        for (int c = 0; c < 11; c++) begin
            set_req4(c < 3, 4'(c));
            @(negedge clk);
            if (c < 3) begin
                checks++;
                if ({bus4.req0_rdy, bus4.req1_rdy} !== 2'b10) begin
                    errors++; $display("FAIL lat4_rdy c=%0d got %b exp 10", c, {bus4.req0_rdy, bus4.req1_rdy});
                end
            end
            if (c >= 6 && c <= 8) begin
                et = 4'(c - 6);
                exp_rsp = {1'b1, 1'b0, et, exp_y(1'b0, et)};
                checks++;
                if ({bus4.rsp_vld, bus4.rsp_id, bus4.rsp_tag, bus4.rsp_y_sgn, bus4.rsp_y_exp,
                     bus4.rsp_y_man_dn} !== exp_rsp) begin
                    errors++; $display("FAIL lat4_rsp c=%0d got %h exp %h", c,
                        {bus4.rsp_vld, bus4.rsp_id, bus4.rsp_tag, bus4.rsp_y_sgn, bus4.rsp_y_exp,
                         bus4.rsp_y_man_dn}, exp_rsp);
                end
            end else begin
                checks++;
                if (bus4.rsp_vld !== 1'b0) begin
                    errors++; $display("FAIL lat4_rsp_idle c=%0d got %b exp 0", c, bus4.rsp_vld);
                end
            end
            exp_busy = (c >= 1 && c <= 8);
            checks++;
            if (bus4.busy !== exp_busy) begin
                errors++; $display("FAIL lat4_busy c=%0d got %b exp %b", c, bus4.busy, exp_busy);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_single_port_then_both();
        test_sched_en();
        test_reset_mid_op();
        test_lat4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
